// File: rtl/mod_count_monitor.sv
// Sequence checker for a mod-MOD counter: locks on a 0 sample, then follows
// 0..MOD-1, pulsing on each legal wrap and flagging any skip, repeat or range error.
//
// state  | meaning
// IDLE   | waiting for the first 0 sample after reset/clear; no errors raised
// TRACK  | locked; each sample must equal the expected next value
// RESYNC | error seen; waiting for a 0 sample to relock, no further errors
module mod_count_monitor #(
  parameter int CW  = 3,
  parameter int MOD = 7,
  parameter int SW  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [CW-1:0] in_count,
  input  logic          clear,
  output logic          locked,
  output logic          wrap_pulse,
  output logic          err_pulse,
  output logic          err_sticky,
  output logic [SW-1:0] wrap_cnt,
  output logic [SW-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, TRACK, RESYNC} state_t;

  localparam logic [CW-1:0] LAST = CW'(MOD - 1);

  state_t        state;
  logic [CW-1:0] expected;
  logic          in_range;
  logic          match;

  assign in_range = ({1'b0, in_count} < (CW+1)'(MOD));
  assign match    = in_range && (in_count == expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      expected   <= '0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      wrap_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      if (clear) begin
        state      <= IDLE;
        expected   <= '0;
        locked     <= 1'b0;
        err_sticky <= 1'b0;
        wrap_cnt   <= '0;
        err_cnt    <= '0;
      end else if (in_valid) begin
        case (state)
          IDLE, RESYNC: begin
            if (in_count == '0) begin
              state    <= TRACK;
              locked   <= 1'b1;
              expected <= CW'(1);
            end
          end
          TRACK: begin
            if (match) begin
              expected <= (in_count == LAST) ? '0 : in_count + 1'b1;
              // expected is only 0 here after matching LAST, so this is a legal wrap
              if (in_count == '0) begin
                wrap_pulse <= 1'b1;
                if (wrap_cnt != '1) wrap_cnt <= wrap_cnt + 1'b1;
              end
            end else begin
              err_pulse  <= 1'b1;
              err_sticky <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
              state  <= RESYNC;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
